// File: rtl/iagc_pkg.sv
// -----------------------------------------------------------------------------
// iagc_pkg
// Shared definitions for the IAGC front end: status code width, the status
// codes published by the IAGC control FSM, and the trigger qualifier state.
// -----------------------------------------------------------------------------
package iagc_pkg;

    localparam int unsigned IAGC_STATUS_SIZE = 4;

    localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_RESET = 4'b0000;
    localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_INIT  = 4'b0001;
    localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_IDLE  = 4'b0010;

    // Width of the trigger delay counter; DELAY_SAMPLES is limited to 0..255.
    localparam int unsigned TRIG_DELAY_W = 8;

    typedef enum logic [1:0] {
        TRIG_DISARMED = 2'd0,
        TRIG_ARMED    = 2'd1,
        TRIG_FIRE     = 2'd2
    } trig_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the i_clock domain through SYNC_STAGES
// flops and produces a registered one-cycle pulse on each rising edge of the
// synchronised level. Intended for any external strobe, not just the gate.
//
// Ports
//   i_clock    in  1  sampling clock
//   i_reset_n  in  1  asynchronous active-low reset, clears every stage
//   i_async    in  1  asynchronous input level
//   o_rise     out 1  registered rising-edge pulse, one i_clock cycle wide
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_dly_q;
    logic                   rise_q;
    logic                   level_s;
    logic                   rise_d;

    assign level_s = sync_q[SYNC_STAGES-1];

    // The delayed copy resets low, so an input already high at reset
    // release is reported as a rising edge.
    assign rise_d = level_s & ~level_dly_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q      <= '0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], i_async};
            level_dly_q <= level_s;
            rise_q      <= rise_d;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/sample_trigger.sv
// -----------------------------------------------------------------------------
// sample_trigger
// Trigger qualifier for the IAGC front end. Each accepted rising edge of the
// external gate yields exactly one o_valid strobe, placed on an ADC data-valid
// cycle after DELAY_SAMPLES qualifying valid cycles. Triggers are honoured only
// while the IAGC status reads IDLE; any other status drops the trigger.
//
// Ports
//   i_clock           in  1                 system clock
//   i_reset_n         in  1                 asynchronous active-low reset
//   i_iagc_status     in  IAGC_STATUS_SIZE  IAGC FSM state code
//   i_adc_data_valid  in  1                 ADC sample valid level
//   i_gate            in  1                 external trigger gate (async)
//   o_valid           out 1                 one-cycle trigger strobe, registered
//
// State table
//   state          | meaning
//   TRIG_DISARMED  | waiting for a gate rising edge while IDLE
//   TRIG_ARMED     | edge accepted, counting qualifying ADC valid cycles
//   TRIG_FIRE      | o_valid high for this single cycle
// -----------------------------------------------------------------------------
module sample_trigger
    import iagc_pkg::*;
#(
    parameter int unsigned                 IAGC_STATUS_SIZE = iagc_pkg::IAGC_STATUS_SIZE,
    parameter logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_IDLE = iagc_pkg::IAGC_STATUS_IDLE,
    parameter int unsigned                 SYNC_STAGES      = 2,
    parameter int unsigned                 DELAY_SAMPLES    = 0
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status,
    input  logic                        i_adc_data_valid,
    input  logic                        i_gate,
    output logic                        o_valid
);

    localparam logic [TRIG_DELAY_W-1:0] DELAY_LOAD = TRIG_DELAY_W'(DELAY_SAMPLES);

    trig_state_e             state_q, state_d;
    logic [TRIG_DELAY_W-1:0] cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic                    gate_rise;
    logic                    idle;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_gate_sync (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_async   (i_gate),
        .o_rise    (gate_rise)
    );

    assign idle = (i_iagc_status == IAGC_STATUS_IDLE);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= TRIG_DISARMED;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        if (!idle) begin
            // Leaving IDLE cancels everything, including a fire decided this cycle.
            state_d = TRIG_DISARMED;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                TRIG_DISARMED: begin
                    if (gate_rise) begin
                        state_d = TRIG_ARMED;
                        cnt_d   = DELAY_LOAD;
                    end
                end
                TRIG_ARMED: begin
                    // Further gate edges are ignored here; nothing is queued.
                    if (i_adc_data_valid) begin
                        if (cnt_q == '0) begin
                            state_d = TRIG_FIRE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                TRIG_FIRE: begin
                    state_d = TRIG_DISARMED;
                end
                default: begin
                    state_d = TRIG_DISARMED;
                    cnt_d   = '0;
                end
            endcase
        end

        valid_d = (state_d == TRIG_FIRE);
    end

    assign o_valid = valid_q;

endmodule

// File: tb/tb_sample_trigger.sv
// -----------------------------------------------------------------------------
// tb_sample_trigger
// Two instances share stimulus: DELAY_SAMPLES=0 and DELAY_SAMPLES=3.
// The reference model tracks the sampled gate history in a queue and keeps an
// armed flag, a remaining-sample count and a pending pulse per instance.
// -----------------------------------------------------------------------------
module tb_sample_trigger;
    import iagc_pkg::*;

    localparam int SYNC = 2;
    localparam int HIST = SYNC + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] status;
    logic       adc_valid;
    logic       gate;
    logic [1:0] ov;

    always #4 clk = ~clk;

    sample_trigger #(.SYNC_STAGES(SYNC), .DELAY_SAMPLES(0)) u_d0 (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_iagc_status    (status),
        .i_adc_data_valid (adc_valid),
        .i_gate           (gate),
        .o_valid          (ov[0])
    );

    sample_trigger #(.SYNC_STAGES(SYNC), .DELAY_SAMPLES(3)) u_d3 (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_iagc_status    (status),
        .i_adc_data_valid (adc_valid),
        .i_gate           (gate),
        .o_valid          (ov[1])
    );

    int n_assert = 0;
    int n_fail   = 0;
    int pulses [2];

    bit hist [$];
    bit m_armed [2];
    int m_rem   [2];
    bit m_pulse [2];

    function automatic int delay_of(input int idx);
        return (idx == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        hist.delete();
        for (int k = 0; k < HIST; k++) hist.push_back(1'b0);
        for (int i = 0; i < 2; i++) begin
            m_armed[i] = 1'b0;
            m_rem[i]   = 0;
            m_pulse[i] = 1'b0;
        end
    endfunction

    // One rising edge of the clock, applied to the inputs present at that edge.
    function automatic void model_edge();
        bit rise;
        bit is_idle;
        hist.push_front(gate);
        void'(hist.pop_back());
        // hist[k] is the gate sample taken k edges ago; the edge reaches the
        // qualifier SYNC+1 edges after it was sampled.
        rise    = hist[SYNC+1] && !hist[SYNC+2];
        is_idle = (status == IAGC_STATUS_IDLE);
        for (int i = 0; i < 2; i++) begin
            if (!is_idle) begin
                m_armed[i] = 1'b0;
                m_rem[i]   = 0;
                m_pulse[i] = 1'b0;
            end else if (m_pulse[i]) begin
                m_pulse[i] = 1'b0;
            end else if (m_armed[i]) begin
                if (adc_valid) begin
                    if (m_rem[i] == 0) begin
                        m_armed[i] = 1'b0;
                        m_pulse[i] = 1'b1;
                    end else begin
                        m_rem[i] = m_rem[i] - 1;
                    end
                end
            end else if (rise) begin
                m_armed[i] = 1'b1;
                m_rem[i]   = delay_of(i);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("o_valid[d%0d]", delay_of(i)), {31'd0, ov[i]}, {31'd0, m_pulse[i]});
            if (ov[i] === 1'b1) pulses[i]++;
        end
    endtask

    task automatic do_reset(input int ns);
        rst_n = 1'b0;
        model_clear();
        #(ns);
        rst_n = 1'b1;
    endtask

    task automatic wait_pulse(input int idx, input int budget, output int n);
        n = -1;
        for (int t = 1; t <= budget; t++) begin
            tick();
            if (ov[idx] === 1'b1) begin
                n = t;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1, n, f0, f3, hold;
        pulses[0] = 0;
        pulses[1] = 0;
        status    = IAGC_STATUS_RESET;
        adc_valid = 1'b1;
        gate      = 1'b0;
        rst_n     = 1'b1;
        model_clear();
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_o_valid_d0", {31'd0, ov[0]}, 32'd0);
        check("reset_o_valid_d3", {31'd0, ov[1]}, 32'd0);
        #8;
        rst_n = 1'b1;

        // Gate pulse while status is RESET then INIT: nothing fires, and the
        // edge is not remembered once IDLE arrives.
        p0 = pulses[0]; p1 = pulses[1];
        repeat (3) tick();
        gate = 1'b1;
        repeat (4) tick();
        status = IAGC_STATUS_INIT;
        repeat (3) tick();
        gate = 1'b0;
        repeat (6) tick();
        status = IAGC_STATUS_IDLE;
        repeat (8) tick();
        check("not_idle_pulses_d0", pulses[0] - p0, 0);
        check("not_idle_pulses_d3", pulses[1] - p1, 0);

        // Gate held ~100 ns in IDLE with valid high: one pulse, 4 clocks after sampling.
        p0 = pulses[0]; p1 = pulses[1];
        gate = 1'b1;
        wait_pulse(0, 20, n);
        check("latency_d0", n, 5);
        repeat (8) tick();
        gate = 1'b0;
        repeat (8) tick();
        check("held_gate_pulses_d0", pulses[0] - p0, 1);
        check("held_gate_pulses_d3", pulses[1] - p1, 1);

        // Armed with valid low; valid arrives 10 cycles later.
        p0 = pulses[0]; p1 = pulses[1];
        adc_valid = 1'b0;
        gate      = 1'b1;
        repeat (10) tick();
        check("valid_low_no_pulse_d0", pulses[0] - p0, 0);
        gate      = 1'b0;
        adc_valid = 1'b1;
        f0 = -1; f3 = -1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (ov[0] === 1'b1 && f0 < 0) f0 = t;
            if (ov[1] === 1'b1 && f3 < 0) f3 = t;
        end
        check("valid_rise_latency_d0", f0, 1);
        check("valid_rise_latency_d3", f3, 4);
        check("valid_rise_pulses_d3", pulses[1] - p1, 1);

        // Status to INIT while armed, then back to IDLE: trigger is lost.
        p0 = pulses[0]; p1 = pulses[1];
        adc_valid = 1'b0;
        gate      = 1'b1;
        repeat (6) tick();
        gate   = 1'b0;
        status = IAGC_STATUS_INIT;
        repeat (2) tick();
        status    = IAGC_STATUS_IDLE;
        adc_valid = 1'b1;
        repeat (10) tick();
        check("init_while_armed_d0", pulses[0] - p0, 0);
        check("init_while_armed_d3", pulses[1] - p1, 0);

        // Status leaves IDLE on the very cycle the fire condition appears.
        adc_valid = 1'b0;
        gate      = 1'b1;
        repeat (6) tick();
        gate      = 1'b0;
        adc_valid = 1'b1;
        status    = IAGC_STATUS_INIT;
        tick();
        status = IAGC_STATUS_IDLE;
        repeat (8) tick();
        check("fire_vs_not_idle_d0", pulses[0] - p0, 0);
        check("fire_vs_not_idle_d3", pulses[1] - p1, 0);

        // Reset for 20 ns while armed: no pulse afterwards.
        adc_valid = 1'b0;
        gate      = 1'b1;
        repeat (6) tick();
        gate = 1'b0;
        do_reset(20);
        adc_valid = 1'b1;
        repeat (12) tick();
        check("reset_armed_d0", pulses[0] - p0, 0);
        check("reset_armed_d3", pulses[1] - p1, 0);

        // Reset while the strobe is high clears it immediately.
        gate = 1'b1;
        wait_pulse(0, 20, n);
        check("pre_reset_pulse_d0", n, 5);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("reset_clears_o_valid", {31'd0, ov[0]}, 32'd0);
        gate = 1'b0;
        #19;
        rst_n = 1'b1;
        p0 = pulses[0]; p1 = pulses[1];
        repeat (12) tick();
        check("post_reset_quiet_d0", pulses[0] - p0, 0);
        check("post_reset_quiet_d3", pulses[1] - p1, 0);

        // Two gate pulses 80 ns apart: two separate strobes.
        p0 = pulses[0]; p1 = pulses[1];
        gate = 1'b1;
        repeat (2) tick();
        gate = 1'b0;
        repeat (8) tick();
        gate = 1'b1;
        repeat (2) tick();
        gate = 1'b0;
        repeat (15) tick();
        check("two_pulses_d0", pulses[0] - p0, 2);
        check("two_pulses_d3", pulses[1] - p1, 2);

        // Gate already high when reset releases counts as a rising edge.
        p0 = pulses[0]; p1 = pulses[1];
        gate = 1'b1;
        do_reset(20);
        repeat (12) tick();
        gate = 1'b0;
        repeat (4) tick();
        check("gate_high_at_release_d0", pulses[0] - p0, 1);
        check("gate_high_at_release_d3", pulses[1] - p1, 1);

        // Random traffic against the model.
        hold = 0;
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                gate = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 9);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 99) < 88) status = IAGC_STATUS_IDLE;
            else                           status = 4'($urandom_range(0, 15));
            adc_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) do_reset(12);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
